// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer: drives an external single-round datapath and key expansion.
// Optional synchronous abort input is enabled with `define AES_ROUND_CTRL_ABORT_EN.
module aes_round_ctrl #(
  parameter int NR = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef AES_ROUND_CTRL_ABORT_EN
  input  logic                    abort,
`endif
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [127:0]            in_data,
  input  logic [127:0]            in_key,
  output logic [127:0]            key_q,
  input  logic [128*(NR+1)-1:0]   fullkeys,
  output logic [127:0]            rd_state,
  output logic [127:0]            rd_key,
  output logic                    rd_final,
  input  logic [127:0]            rd_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [127:0]            out_data,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ROUND = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [3:0] NR_L = 4'(NR);

  state_t       state_r;
  logic [3:0]   rnd_r;
  logic [127:0] data_r;
  logic [127:0] key_r;
  logic [127:0] out_data_r;
  logic         out_valid_r;
  logic         busy_r;
  logic         in_ready_r;
  logic         abort_s;
  logic [127:0] rd_state_s;
  logic [127:0] rd_key_s;
  logic         rd_final_s;
  logic [127:0] rk_s [0:NR];

`ifdef AES_ROUND_CTRL_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // Round key r sits at the top of the schedule for r = 0 and moves down 128 bits per round.
  for (genvar g = 0; g <= NR; g++) begin : g_rk
    assign rk_s[g] = fullkeys[128*(NR-g) +: 128];
  end

  // Datapath-facing outputs are only live in ROUND and forced to zero elsewhere.
  always_comb begin
    rd_state_s = 128'd0;
    rd_key_s   = 128'd0;
    rd_final_s = 1'b0;
    if (state_r == ROUND) begin
      rd_state_s = data_r;
      rd_final_s = (rnd_r == NR_L);
      if (rnd_r <= NR_L) begin
        rd_key_s = rk_s[rnd_r];
      end else begin
        rd_key_s = 128'd0;
      end
    end else begin
      rd_state_s = 128'd0;
      rd_key_s   = 128'd0;
      rd_final_s = 1'b0;
    end
  end

  // Control FSM with round counter, state register and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      rnd_r       <= 4'd0;
      data_r      <= 128'd0;
      key_r       <= 128'd0;
      out_data_r  <= 128'd0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            key_r      <= in_key;
            data_r     <= in_data ^ in_key;
            rnd_r      <= 4'd1;
            state_r    <= ROUND;
            busy_r     <= 1'b1;
            in_ready_r <= 1'b0;
          end
        end
        ROUND: begin
          if (abort_s) begin
            state_r    <= IDLE;
            rnd_r      <= 4'd0;
            data_r     <= 128'd0;
            busy_r     <= 1'b0;
            in_ready_r <= 1'b1;
          end else begin
            data_r <= rd_result;
            if (rnd_r >= NR_L) begin
              state_r     <= DONE;
              out_valid_r <= 1'b1;
              out_data_r  <= rd_result;
            end else begin
              rnd_r <= rnd_r + 4'd1;
            end
          end
        end
        DONE: begin
          // Abort wins over a simultaneous output handshake; both land in IDLE.
          if (abort_s || out_ready) begin
            state_r     <= IDLE;
            rnd_r       <= 4'd0;
            data_r      <= 128'd0;
            out_data_r  <= 128'd0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          rnd_r       <= 4'd0;
          data_r      <= 128'd0;
          out_data_r  <= 128'd0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign key_q     = key_r;
  assign rd_state  = rd_state_s;
  assign rd_key    = rd_key_s;
  assign rd_final  = rd_final_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: supplies a behavioural AES-128 key expansion and round datapath,
// then checks FIPS-197 vectors, backpressure, ignored input, mid-run reset and (optionally) abort.
module tb_aes_round_ctrl;

  logic           clk;
  logic           rst_n;
  logic           abort;
  logic           in_valid;
  logic           in_ready;
  logic [127:0]   in_data;
  logic [127:0]   in_key;
  logic [127:0]   key_q;
  logic [1407:0]  fullkeys;
  logic [127:0]   rd_state;
  logic [127:0]   rd_key;
  logic           rd_final;
  logic [127:0]   rd_result;
  logic           out_valid;
  logic           out_ready;
  logic [127:0]   out_data;
  logic           busy;

  int check_cnt = 0;
  int error_cnt = 0;

  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;

  aes_round_ctrl #(.NR(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .abort     (abort),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .key_q     (key_q),
    .fullkeys  (fullkeys),
    .rd_state  (rd_state),
    .rd_key    (rd_key),
    .rd_final  (rd_final),
    .rd_result (rd_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from the GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p = x;
    logic [7:0] r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    if (x == 8'h00) r = 8'h00;
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [1407:0] key_expand(input logic [127:0] k);
    logic [31:0]   w [0:43];
    logic [31:0]   t;
    logic [7:0]    rc = 8'h01;
    logic [1407:0] fk;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h000000};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) fk[1407-32*i -: 32] = w[i];
    return fk;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic fin);
    logic [7:0]   b [0:15];
    logic [7:0]   t [0:15];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r + 4*c] = b[r + 4*((c + r) % 4)];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        t[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ k;
  endfunction

  always_comb fullkeys  = key_expand(key_q);
  always_comb rd_result = aes_round(rd_state, rd_key, rd_final);

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    check_cnt++;
    if (got !== exp) begin
      error_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [127:0] pt, input logic [127:0] key);
    in_data  = pt;
    in_key   = key;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = ~pt;
    in_key   = ~key;
    check_eq("accept_busy", busy, 128'd1);
    check_eq("accept_in_ready", in_ready, 128'd0);
    check_eq("accept_key_q", key_q, key);
    check_eq("accept_rd_state", rd_state, pt ^ key);
  endtask

  // Full transaction; latency is counted in cycles inclusive of the accept cycle.
  task automatic run_vector(input logic [127:0] pt, input logic [127:0] key,
                            input logic [127:0] exp, input int stall, input bit poke);
    int k = 0;
    bit seen = 1'b0;
    accept(pt, key);
    while (!seen && k < 30) begin
      if (k <= 9) check_eq("rd_final", rd_final, (k == 9) ? 128'd1 : 128'd0);
      if (poke && k == 3) begin
        in_valid = 1'b1;
        in_data  = 128'hdeadbeef_00000000_cafef00d_12345678;
      end
      tick();
      in_valid = 1'b0;
      k++;
      seen = out_valid;
    end
    check_eq("latency", 128'(k + 1), 128'd11);
    check_eq("out_data", out_data, exp);
    check_eq("done_in_ready", in_ready, 128'd0);
    for (int i = 0; i < stall; i++) begin
      tick();
      check_eq("stall_valid", out_valid, 128'd1);
      check_eq("stall_data", out_data, exp);
      check_eq("stall_in_ready", in_ready, 128'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("post_valid", out_valid, 128'd0);
    check_eq("post_in_ready", in_ready, 128'd1);
    check_eq("post_busy", busy, 128'd0);
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_out_valid"}, out_valid, 128'd0);
    check_eq({tag, "_busy"}, busy, 128'd0);
    check_eq({tag, "_rd_final"}, rd_final, 128'd0);
    check_eq({tag, "_rd_state"}, rd_state, 128'd0);
    check_eq({tag, "_rd_key"}, rd_key, 128'd0);
    check_eq({tag, "_out_data"}, out_data, 128'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 128'd0;
    in_key    = 128'd0;
    out_ready = 1'b0;
    repeat (3) tick();
    check_quiet("reset");
    check_eq("reset_key_q", key_q, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("reset_in_ready", in_ready, 128'd1);
    tick();

    run_vector(PT1, K1, CT1, 0, 1'b0);
    run_vector(PT2, K2, CT2, 5, 1'b0);
    run_vector(PT1, K1, CT1, 0, 1'b1);

    // Reset while rnd = 5, then a fresh vector must still complete.
    accept(PT2, K2);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check_quiet("midreset");
    check_eq("midreset_key_q", key_q, 128'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("midreset_no_valid", out_valid, 128'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_vector(PT1, K1, CT1, 0, 1'b0);

`ifdef AES_ROUND_CTRL_ABORT_EN
    // Abort is a no-op in IDLE.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("idle_abort_in_ready", in_ready, 128'd1);
    accept(PT1, K1);
    repeat (2) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_quiet("abort");
    check_eq("abort_in_ready", in_ready, 128'd1);
    run_vector(PT2, K2, CT2, 0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
    $finish;
  end

endmodule
